// File: rtl/raw_crop_pkg.sv
// Shared types and widths for the raw_crop pixel-window block.
// Holds the frame-tracking state enum and counter widths.
// No logic; imported by the top-level crop module.
package raw_crop_pkg;

  localparam int COL_W = 12;
  localparam int ROW_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    SKIP  = 2'd2
  } crop_state_t;

endpackage

// File: rtl/raw_crop_sync_edge.sv
// sync_edge: registers one input and flags its rising/falling edges.
// Latency: q is 1 cycle behind d; rise/fall are combinational from q.
// The first sample after reset primes the history, so a level that is
// already high when reset releases is not reported as a rising edge.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic qq;
  logic primed;

  // Input register plus one-deep history; history is seeded on first sample
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= 1'b0;
      qq     <= 1'b0;
      primed <= 1'b0;
    end else begin
      q      <= d;
      qq     <= primed ? q : d;
      primed <= 1'b1;
    end
  end

  assign rise = q & ~qq;
  assign fall = ~q & qq;

endmodule

// File: rtl/raw_crop.sv
// raw_crop: tracks fv/lv framing and passes a rectangular window of RAW10
// pixels with SOF/EOL markers. Latency 2 cycles, fixed; no backpressure.
// Optional RAW_CROP_STATS_EN build reports last frame width/height.
module raw_crop
  import raw_crop_pkg::*;
#(
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fv,
  input  logic             lv,
  input  logic             pix_en,
  input  logic [9:0]       pix_data,
  input  logic             enable,
  output logic             out_valid,
  output logic [9:0]       out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done,
  output logic             frame_short,
  output logic [COL_W-1:0] last_width,
  output logic [ROW_W-1:0] last_height
);

  // 13-bit window bounds so X0+WIDTH / Y0+HEIGHT cannot overflow
  localparam logic [12:0] X_LO = 13'(X0);
  localparam logic [12:0] X_HI = 13'(X0 + WIDTH);
  localparam logic [12:0] Y_LO = 13'(Y0);
  localparam logic [12:0] Y_HI = 13'(Y0 + HEIGHT);

  logic fv_q, fv_rise, fv_fall;
  logic lv_q, lv_rise, lv_fall;
  logic line_in;

  // lv only matters inside fv; gating here also turns an fv drop mid-line
  // into a line end in the same cycle as the frame end
  assign line_in = lv & fv;

  sync_edge u_fv (.clk(clk), .reset(reset), .d(fv),      .q(fv_q), .rise(fv_rise), .fall(fv_fall));
  sync_edge u_lv (.clk(clk), .reset(reset), .d(line_in), .q(lv_q), .rise(lv_rise), .fall(lv_fall));

  logic       pix_q;
  logic [9:0] data_q;
  logic       enable_q;

  // Align pixel strobe, data and enable with the registered fv/lv
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q    <= 1'b0;
      data_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      pix_q    <= pix_en;
      data_q   <= pix_data;
      enable_q <= enable;
    end
  end

  crop_state_t state, state_nxt;
  logic        frame_end;

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; frame_end only for accepted frames
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (fv_rise) state_nxt = enable_q ? FRAME : SKIP;
      FRAME:   if (fv_fall) begin
                 state_nxt = IDLE;
                 frame_end = 1'b1;
               end
      SKIP:    if (fv_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [COL_W-1:0] col, col_eff, col_nxt;
  logic [ROW_W-1:0] row, row_eff, row_nxt;
  logic [12:0]      c13, r13;
  logic             short_q, short_nxt;
  logic             act, pix_cnt, in_x, in_y, pass, row_end;

  // Window decision and counter updates; a line/frame start in the same
  // cycle as a pixel is applied before that pixel is positioned
  always_comb begin
    act       = (state == FRAME) || ((state == IDLE) && fv_rise && enable_q);
    pix_cnt   = pix_q && lv_q && fv_q;
    col_eff   = lv_rise ? '0 : col;
    row_eff   = fv_rise ? '0 : row;
    c13       = {1'b0, col_eff};
    r13       = {2'b0, row_eff};
    in_x      = (c13 >= X_LO) && (c13 < X_HI);
    in_y      = (r13 >= Y_LO) && (r13 < Y_HI);
    pass      = act && pix_cnt && in_x && in_y;
    row_end   = lv_fall && (state == FRAME);
    col_nxt   = col_eff;
    if (pix_cnt && (col_eff != {COL_W{1'b1}})) col_nxt = col_eff + 1'b1;
    row_nxt   = row_eff;
    if (row_end && (row_eff != {ROW_W{1'b1}})) row_nxt = row_eff + 1'b1;
    short_nxt = fv_rise ? 1'b0 : short_q;
    if (row_end && in_y && ({1'b0, col} < X_HI)) short_nxt = 1'b1;
  end

  // Position counters and sticky short-row flag
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      short_q <= 1'b0;
    end else begin
      col     <= col_nxt;
      row     <= row_nxt;
      short_q <= short_nxt;
    end
  end

  // Output stage; data holds when no pixel passes
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      out_valid   <= pass;
      if (pass) out_data <= data_q;
      out_sof     <= pass && (c13 == X_LO) && (r13 == Y_LO);
      out_eol     <= pass && ((c13 + 13'd1) == X_HI);
      frame_done  <= frame_end;
      frame_short <= frame_end && (short_nxt || ({2'b0, row_nxt} < Y_HI));
    end
  end

`ifdef RAW_CROP_STATS_EN
  logic [COL_W-1:0] line_w;

  // Width of the most recent line; published with the frame height at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      line_w      <= '0;
      last_width  <= '0;
      last_height <= '0;
    end else begin
      if (row_end) line_w <= col;
      if (frame_end) begin
        last_width  <= row_end ? col : line_w;
        last_height <= row_nxt;
      end
    end
  end
`else
  assign last_width  = '0;
  assign last_height = '0;
`endif

endmodule
